// File: rtl/ram_be_pkg.sv
// Shared types and encodings for the byte-enable single-port RAM.
// Holds the FSM state encodings, the WRITE_MODE encodings and a power-of-two helper.
package ram_be_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Storage array with per-byte write and a registered read port.
// The storage itself is never reset; only the read register clears on rst.
import ram_be_pkg::*;

module ram_sp_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int WRITE_MODE = WM_READ_FIRST
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          re,
  input  logic [DATA_WIDTH/8-1:0]       wen,
  input  logic [$clog2(DEPTH)-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;

  assign old_word = mem[addr];

  always_comb begin
    merged = old_word;
    for (int b = 0; b < NB; b++) begin
      if (wen[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (en && (|wen)) mem[addr] <= merged;
  end

  // Read register only loads on accepted requests, so it holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (WRITE_MODE == WM_WRITE_FIRST) ? merged : old_word;
    end
  end

endmodule

// File: rtl/ram_be_top.sv
// Single-port RAM with byte enables, 1/2-cycle read latency, ready/valid handshake
// and an optional post-reset zero-clear sweep.
import ram_be_pkg::*;

module ram_be_top #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 256,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_MODE     = WM_READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ram_req,
  output logic                    ram_ready,
  input  logic [DATA_WIDTH/8-1:0] ram_wen,
  input  logic [ADDR_WIDTH-1:0]   ram_addr,
  input  logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic                    ram_rvalid,
  output logic                    init_done
);

  localparam int IW = $clog2(DEPTH);
  localparam int NB = DATA_WIDTH / 8;
  localparam state_e ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("ram_be_top: DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
    $error("ram_be_top: RD_LATENCY must be 1 or 2");
  end
  if (!is_pow2(DEPTH)) begin : g_chk_depth
    $error("ram_be_top: DEPTH must be a power of two >= 2");
  end
  if (ADDR_WIDTH < IW) begin : g_chk_aw
    $error("ram_be_top: ADDR_WIDTH too narrow for DEPTH");
  end

  state_e          state;
  state_e          state_nx;
  logic [IW-1:0]   cnt;
  logic            sweep;
  logic            accept;
  logic            vld1;
  logic            arr_en;
  logic [NB-1:0]   arr_wen;
  logic [IW-1:0]   arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sweep     = 1'b0;
    ram_ready = 1'b0;
    init_done = 1'b0;
    case (state)
      ST_CLEAR: begin
        sweep = 1'b1;
        if (cnt == IW'(DEPTH - 1)) state_nx = ST_RUN;
      end
      ST_RUN: begin
        ram_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (sweep) cnt <= cnt + IW'(1);
  end

  assign accept = ram_req & ram_ready;

  // The sweep owns the array port while clearing; requests are ignored then.
  always_comb begin
    arr_en    = sweep | accept;
    arr_wen   = '0;
    arr_addr  = ram_addr[IW-1:0];
    arr_wdata = ram_wdata;
    if (sweep) begin
      arr_wen   = '1;
      arr_addr  = cnt;
      arr_wdata = '0;
    end else if (accept) begin
      arr_wen   = ram_wen;
    end
  end

  if (ADDR_WIDTH > IW) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^ram_addr[ADDR_WIDTH-1:IW];
  end

  ram_sp_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .WRITE_MODE (WRITE_MODE)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (arr_en),
    .re    (accept),
    .wen   (arr_wen),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld1 <= 1'b0;
    else     vld1 <= accept;
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  vld2;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld2    <= 1'b0;
        rdata_q <= '0;
      end else begin
        vld2 <= vld1;
        if (vld1) rdata_q <= arr_rdata;
      end
    end

    assign ram_rvalid = vld2;
    assign ram_rdata  = rdata_q;
  end else begin : g_lat1
    assign ram_rvalid = vld1;
    assign ram_rdata  = arr_rdata;
  end

endmodule

// File: tb/tb_ram_be_top.sv
// Scoreboard bench for ram_be_top: dut_a (latency 2, read-first, clear sweep)
// and dut_b (latency 1, write-first, no sweep) driven by directed vectors.
module tb_ram_be_top;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        req_a, req_b;
  logic        ready_a, ready_b;
  logic [3:0]  wen_a, wen_b;
  logic [15:0] addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;
  logic        done_a, done_b;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses_a = 0;
  int   pulses_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_be_top #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .RD_LATENCY(2),
               .WRITE_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst_a), .ram_req(req_a), .ram_ready(ready_a), .ram_wen(wen_a),
    .ram_addr(addr_a), .ram_wdata(wdata_a), .ram_rdata(rdata_a),
    .ram_rvalid(rvalid_a), .init_done(done_a));

  ram_be_top #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .RD_LATENCY(1),
               .WRITE_MODE(1), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .rst(rst_b), .ram_req(req_b), .ram_ready(ready_b), .ram_wen(wen_b),
    .ram_addr(addr_b), .ram_wdata(wdata_b), .ram_rdata(rdata_b),
    .ram_rvalid(rvalid_b), .init_done(done_b));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: pops one expectation per response and checks data and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rvalid_a) begin
      pulses_a++;
      vectors++;
      if (q_a.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_a: unexpected rvalid, rdata %h at cycle %0d", rdata_a, cyc);
      end else begin
        e = q_a.pop_front();
        if (rdata_a !== e.data || cyc != e.due) begin
          miscompares++;
          $display("FAIL rsp_a: got %h at cycle %0d, expected %h at cycle %0d",
                   rdata_a, cyc, e.data, e.due);
        end
      end
    end else if (q_a.size() > 0 && q_a[0].due < cyc) begin
      e = q_a.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL rsp_a: missing response, expected %h at cycle %0d", e.data, e.due);
    end
    if (rvalid_b) begin
      pulses_b++;
      vectors++;
      if (q_b.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_b: unexpected rvalid, rdata %h at cycle %0d", rdata_b, cyc);
      end else begin
        e = q_b.pop_front();
        if (rdata_b !== e.data || cyc != e.due) begin
          miscompares++;
          $display("FAIL rsp_b: got %h at cycle %0d, expected %h at cycle %0d",
                   rdata_b, cyc, e.data, e.due);
        end
      end
    end else if (q_b.size() > 0 && q_b[0].due < cyc) begin
      e = q_b.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL rsp_b: missing response, expected %h at cycle %0d", e.data, e.due);
    end
  end

  // sel=0 drives dut_a, sel=1 drives dut_b; request is accepted at the next posedge.
  task automatic issue(input bit sel, input logic [3:0] wen, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [31:0] want);
    @(negedge clk);
    if (!sel) begin
      check("ready_a", {31'd0, ready_a}, 32'd1);
      req_a = 1'b1; wen_a = wen; addr_a = addr; wdata_a = wdata;
      q_a.push_back('{data: want, due: cyc + 2});
    end else begin
      check("ready_b", {31'd0, ready_b}, 32'd1);
      req_b = 1'b1; wen_b = wen; addr_b = addr; wdata_b = wdata;
      q_b.push_back('{data: want, due: cyc + 1});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_a = 1'b0; wen_a = 4'h0;
    req_b = 1'b0; wen_b = 4'h0;
  endtask

  // Counts cycles with ready_a and done_a both low, starting just after rst release.
  task automatic count_clear(output int n);
    n = 0;
    #1;
    while (!ready_a && !done_a && n < 400) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    int p0;
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 1'b0; wen_a = 4'h0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; wen_b = 4'h0; addr_b = '0; wdata_b = '0;
    repeat (3) @(negedge clk);

    check("reset_rvalid_a", {31'd0, rvalid_a}, 32'd0);
    check("reset_rdata_a",  rdata_a, 32'h0);
    check("reset_done_a",   {31'd0, done_a}, 32'd0);
    check("reset_ready_a",  {31'd0, ready_a}, 32'd0);
    check("reset_done_b",   {31'd0, done_b}, 32'd1);
    check("reset_rdata_b",  rdata_b, 32'h0);

    // Clear sweep: exactly DEPTH cycles not ready
    rst_a = 1'b0; rst_b = 1'b0;
    count_clear(n);
    check("clear_cycles", n, 256);
    check("ready_after_clear", {31'd0, ready_a}, 32'd1);
    check("done_after_clear",  {31'd0, done_a}, 32'd1);

    // Read-first, latency 2 on dut_a
    issue(0, 4'h0, 16'h00f0, 32'h0,        32'h0000_0000);
    issue(0, 4'hf, 16'h00f0, 32'h11223344, 32'h0000_0000);
    issue(0, 4'h0, 16'h00f1, 32'h0,        32'h0000_0000);
    issue(0, 4'h0, 16'h00f0, 32'h0,        32'h1122_3344);
    issue(0, 4'h3, 16'h00f0, 32'hAAAA5555, 32'h1122_3344);
    issue(0, 4'h0, 16'h00f0, 32'h0,        32'h1122_5555);
    issue(0, 4'h8, 16'h00f0, 32'h99000000, 32'h1122_5555);
    issue(0, 4'h0, 16'h00f0, 32'h0,        32'h9922_5555);
    issue(0, 4'hf, 16'h00f0, 32'h11223344, 32'h9922_5555);
    issue(0, 4'hf, 16'h00f0, 32'h0000ff00, 32'h1122_3344);
    issue(0, 4'h0, 16'h00f0, 32'h0,        32'h0000_ff00);
    issue(0, 4'h0, 16'h01f0, 32'h0,        32'h0000_ff00);
    idle();
    repeat (4) @(negedge clk);

    // Burst: five writes then five reads, back-to-back
    for (int i = 0; i < 5; i++)
      issue(0, 4'hf, 16'h00f0 + 16'(i), 32'h0000ff00 + 32'(i * 'h11),
            (i == 0) ? 32'h0000_ff00 : 32'h0);
    for (int i = 0; i < 5; i++)
      issue(0, 4'h0, 16'h00f0 + 16'(i), 32'h0, 32'h0000ff00 + 32'(i * 'h11));
    idle();
    repeat (4) @(negedge clk);

    // Write-first, latency 1 on dut_b
    issue(1, 4'hf, 16'h0020, 32'h11223344, 32'h1122_3344);
    issue(1, 4'hf, 16'h0020, 32'h0000ff00, 32'h0000_ff00);
    issue(1, 4'h1, 16'h0020, 32'h000000aa, 32'h0000_ffaa);
    issue(1, 4'h0, 16'h0020, 32'h0,        32'h0000_ffaa);
    issue(1, 4'hf, 16'h0021, 32'hdeadbeef, 32'hdead_beef);
    idle();
    repeat (3) @(negedge clk);
    check("rdata_hold_b", rdata_b, 32'hdead_beef);

    // Reset with two reads in flight on dut_a
    issue(0, 4'h0, 16'h00f1, 32'h0, 32'h0000_ff11);
    issue(0, 4'h0, 16'h00f2, 32'h0, 32'h0000_ff22);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    req_a = 1'b0;
    q_a.delete();
    p0 = pulses_a;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (100) @(posedge clk);
    check("no_rvalid_after_reset_a", pulses_a - p0, 0);
    check("still_clearing_at_100", {31'd0, done_a}, 32'd0);

    // Reset again mid-sweep: restart from zero
    #1;
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    count_clear(n);
    check("clear_restart_cycles", n, 256);
    issue(0, 4'h0, 16'h00f0, 32'h0, 32'h0000_0000);
    idle();

    // Reset with a read in flight on dut_b; memory survives (no sweep)
    issue(1, 4'h0, 16'h0020, 32'h0, 32'h0000_ffaa);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    req_b = 1'b0;
    q_b.delete();
    p0 = pulses_b;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check("no_rvalid_after_reset_b", pulses_b - p0, 0);
    check("done_b_after_reset", {31'd0, done_b}, 32'd1);
    issue(1, 4'h0, 16'h0020, 32'h0, 32'h0000_ffaa);
    issue(1, 4'h0, 16'h0021, 32'h0, 32'hdead_beef);
    idle();
    repeat (5) @(negedge clk);

    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
